// File: rtl/button_event_pkg.sv
// Shared types and sizing helpers for the button gesture classifier.
package button_event_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } btn_state_t;

    // Counter must hold the larger of the two timeouts; one spare bit keeps headroom.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/level_edge_detect.sv
// Registers the debounced level and flags its rising and falling edges.
module level_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic level_q;

    // Resetting to 0 makes a button held through reset look like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= 1'b0;
        else        level_q <= level_i;
    end

    assign rise_o = level_i & ~level_q;
    assign fall_o = ~level_i & level_q;

endmodule

// File: rtl/button_event_detector.sv
// Turns a debounced button level into one-cycle press/release/click/long-press events.
module button_event_detector
    import button_event_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 100,
    parameter int DOUBLE_CLICK_GAP  = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam int CNT_W = cnt_width(LONG_PRESS_CYCLES, DOUBLE_CLICK_GAP);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DOUBLE_CLICK_GAP - 1);

    logic             rise, fall;
    btn_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q, release_q, single_q, double_q, long_q, busy_q;

    level_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .level_i(btn_level),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Edges are tested before timeouts so a coincident edge always wins.
    // The counter only runs in timed states; IDLE and HELD park it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            cnt_q     <= '0;
            case (state_q)
                IDLE: if (rise) begin
                    state_q <= PRESS1;
                    press_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                PRESS1: if (fall) begin
                    state_q   <= GAP;
                    release_q <= 1'b1;
                end else if (cnt_q == LP_LAST) begin
                    state_q <= HELD;
                    long_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                GAP: if (rise) begin
                    state_q <= PRESS2;
                    press_q <= 1'b1;
                end else if (cnt_q == DC_LAST) begin
                    state_q  <= IDLE;
                    single_q <= 1'b1;
                    busy_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                PRESS2: if (fall) begin
                    state_q   <= IDLE;
                    release_q <= 1'b1;
                    double_q  <= 1'b1;
                    busy_q    <= 1'b0;
                end else if (cnt_q == LP_LAST) begin
                    state_q <= HELD;
                    long_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                HELD: if (fall) begin
                    state_q   <= IDLE;
                    release_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign single_click  = single_q;
    assign double_click  = double_q;
    assign long_press    = long_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Directed gesture checks plus a randomized run with edge/gesture invariants.
module tb_button_event_detector;

    localparam int LP = 10;
    localparam int DG = 6;

    logic clk = 1'b0, rst_n = 1'b0, btn_level = 1'b0;
    logic press_pulse, release_pulse, single_click, double_click, long_press, busy;
    int   checks = 0, errs = 0;

    always #5 clk = ~clk;

    button_event_detector #(.LONG_PRESS_CYCLES(LP), .DOUBLE_CLICK_GAP(DG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .busy         (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: counts pulses, remembers the edge that registered each, checks invariants.
    int   ecount = 0;
    int   n_press = 0, n_rel = 0, n_single = 0, n_double = 0, n_long = 0;
    int   t_press = 0, t_rel = 0, t_single = 0, t_double = 0, t_long = 0, t_bfall = 0;
    logic btn_prev = 1'b0, exp_press = 1'b0, exp_rel = 1'b0;
    logic busy_prev = 1'b0, gest_prev = 1'b0, stress_on = 1'b0;
    int   stress_err = 0, gcnt = 0;

    always @(posedge clk) begin
        ecount++;
        if (!rst_n) begin
            btn_prev = 1'b0; exp_press = 1'b0; exp_rel = 1'b0;
        end else begin
            exp_press = btn_level & ~btn_prev;
            exp_rel   = ~btn_level & btn_prev;
            btn_prev  = btn_level;
        end
    end

    always @(negedge clk) begin
        logic g;
        g = single_click | double_click | long_press;
        if (press_pulse)   begin n_press++;  t_press  = ecount; end
        if (release_pulse) begin n_rel++;    t_rel    = ecount; end
        if (single_click)  begin n_single++; t_single = ecount; end
        if (double_click)  begin n_double++; t_double = ecount; end
        if (long_press)    begin n_long++;   t_long   = ecount; end
        if (busy_prev && !busy) t_bfall = ecount;
        if (stress_on) begin
            if (press_pulse != exp_press || release_pulse != exp_rel) stress_err++;
            if (int'(single_click) + int'(double_click) + int'(long_press) > 1) stress_err++;
            if (g && gest_prev) stress_err++;
            gcnt += int'(g);
            if (busy_prev && !busy && gcnt != 1) stress_err++;
            if (!busy) gcnt = 0;
        end
        gest_prev = g;
        busy_prev = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lvl, input int n);
        btn_level = lvl;
        repeat (n) tick();
    endtask

    int b, p0, r0, s0, d0, l0;
    task automatic snap();
        b = ecount; p0 = n_press; r0 = n_rel; s0 = n_single; d0 = n_double; l0 = n_long;
    endtask

    initial begin
        logic lvl;
        #12;
        chk("reset_outputs", int'({press_pulse, release_pulse, single_click,
                                    double_click, long_press, busy}), 0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle_busy", int'(busy), 0);

        // Single click: high 3 edges, release at b+4, single 6 edges later.
        snap(); drive(1'b1, 3); drive(1'b0, 10);
        chk("sc_press_t", t_press - b, 1);
        chk("sc_rel_t", t_rel - b, 4);
        chk("sc_single_n", n_single - s0, 1);
        chk("sc_single_t", t_single - b, 10);
        chk("sc_busy_fall", t_bfall - b, 10);
        chk("sc_no_other", (n_double - d0) + (n_long - l0), 0);

        // Double click: hold 3, low 4, hold 3, release.
        snap(); drive(1'b1, 3); drive(1'b0, 4); drive(1'b1, 3); drive(1'b0, 10);
        chk("dc_press_n", n_press - p0, 2);
        chk("dc_rel_n", n_rel - r0, 2);
        chk("dc_double_n", n_double - d0, 1);
        chk("dc_double_t", t_double - b, 11);
        chk("dc_rel_t", t_rel - b, 11);
        chk("dc_busy_fall", t_bfall - b, 11);
        chk("dc_no_single", n_single - s0, 0);

        // Long press: hold 15.
        snap(); drive(1'b1, 15); drive(1'b0, 10);
        chk("lp_long_n", n_long - l0, 1);
        chk("lp_long_t", t_long - b, 11);
        chk("lp_rel_t", t_rel - b, 16);
        chk("lp_busy_fall", t_bfall - b, 16);
        chk("lp_no_click", (n_single - s0) + (n_double - d0), 0);

        // Second rise sampled exactly at release+6.
        snap(); drive(1'b1, 3); drive(1'b0, 6); drive(1'b1, 3); drive(1'b0, 10);
        chk("bd_double_n", n_double - d0, 1);
        chk("bd_double_t", t_double - b, 13);
        chk("bd_no_single", n_single - s0, 0);

        // Fall sampled at press+10 beats the long-press timeout.
        snap(); drive(1'b1, 10); drive(1'b0, 10);
        chk("bl_no_long", n_long - l0, 0);
        chk("bl_rel_t", t_rel - b, 11);
        chk("bl_single_t", t_single - b, 17);

        // Reset during GAP while release_pulse is still high.
        drive(1'b1, 3); drive(1'b0, 1);
        chk("rst_inflight", int'(release_pulse), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({press_pulse, release_pulse, single_click,
                                     double_click, long_press, busy}), 0);
        btn_level = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_press_first", int'(press_pulse), 1);
        chk("rst_busy", int'(busy), 1);
        drive(1'b0, 12);
        chk("rst_idle_after", int'(busy), 0);

        // Randomized toggling with invariant checks.
        snap();
        stress_on = 1'b1;
        lvl = 1'b1;
        while (ecount - b < 10000) begin
            drive(lvl, int'($urandom_range(1, 14)));
            lvl = ~lvl;
        end
        drive(1'b0, 30);
        stress_on = 1'b0;
        chk("stress_err", stress_err, 0);
        chk("stress_pr_bal", (n_press - p0) - (n_rel - r0), 0);
        chk("stress_active", int'((n_double - d0) > 0 && (n_single - s0) > 0 && (n_long - l0) > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
